sync_mod_counter: RTL and testbench

Parametrised synchronous up/down counter for the counter library, succeeding the fixed 4-bit asynchronous ripple counter. All bits change on the same `clk` edge, so there are no ripple glitches and the count value is safe to use as a datapath or control input. Adds programmable modulus, direction, parallel load, wrap/saturate mode, an enable prescaler and terminal-count/compare flags for cascading and timer use.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_prescaler.sv | 44 ++++
 rtl/sync_mod_counter.sv | 95 +++++++++
 tb/tb_sync_mod_counter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the synchronous counter library.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Register width needed to hold 0..n-1; a 1-bit register is kept even when n is 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one step pulse per PRESCALE enabled cycles.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  input  logic en,
  output logic step
);

  localparam int PW = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;
  logic          at_last;

  assign at_last = (pc_q == LAST);

  // hold freezes the phase so a step swallowed by a load is not half-consumed
  always_comb begin
    pc_d = pc_q;
    if (clear) begin
      pc_d = '0;
    end else if (en && !hold) begin
      pc_d = at_last ? '0 : pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign step = en && !hold && at_last;

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous modulo up/down counter with load, wrap/saturate mode, prescaled
// enable, registered terminal-count pulse and combinational compare flag.
module sync_mod_counter
  import counter_pkg::*;
#(
  parameter int        WIDTH    = 4,
  parameter int        MODULUS  = 2 ** WIDTH,
  parameter cnt_mode_e MODE     = CNT_WRAP,
  parameter int        PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             match
);

  generate
    if (WIDTH < 1 || PRESCALE < 1 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_params
      $error("sync_mod_counter: illegal WIDTH/MODULUS/PRESCALE combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;
  logic             step;
  logic             at_max;
  logic             at_zero;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .hold (load),
    .en   (en),
    .step (step)
  );

  assign at_max  = (q_q == MAXV);
  assign at_zero = (q_q == '0);

  // tc flags any step that starts at the boundary, whether it wraps or holds
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = (load_val > MAXV) ? MAXV : load_val;
    end else if (step) begin
      if (up) begin
        if (at_max) begin
          tc_d = 1'b1;
          q_d  = (MODE == CNT_SAT) ? q_q : '0;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          tc_d = 1'b1;
          q_d  = (MODE == CNT_SAT) ? q_q : MAXV;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q     = q_q;
  assign tc    = tc_q;
  assign match = (q_q == cmp_val);

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed self-checking bench for sync_mod_counter across several parameter sets.
module tb_sync_mod_counter;
  import counter_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] cmp_val;

  logic [3:0] q0, q1, q2, q3, q4;
  logic       tc0, tc1, tc2, tc3, tc4;
  logic       m0, m1, m2, m3, m4;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: defaults (M=16, wrap, P=1)
  sync_mod_counter u0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .q(q0), .tc(tc0), .match(m0));
  // u1: M=10 wrap
  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .MODE(CNT_WRAP), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .q(q1), .tc(tc1), .match(m1));
  // u2: M=10 saturate
  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .MODE(CNT_SAT), .PRESCALE(1)) u2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .q(q2), .tc(tc2), .match(m2));
  // u3: M=16 wrap, prescale 3
  sync_mod_counter #(.WIDTH(4), .MODULUS(16), .MODE(CNT_WRAP), .PRESCALE(3)) u3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .q(q3), .tc(tc3), .match(m3));
  // u4: M=12 wrap
  sync_mod_counter #(.WIDTH(4), .MODULUS(12), .MODE(CNT_WRAP), .PRESCALE(1)) u4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .q(q4), .tc(tc4), .match(m4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0;
    load_val = 4'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1;
    do_reset();
    checks++;
    if (q0 !== 4'd0 || tc0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_u0 q=%0d tc=%0b expected q=0 tc=0", q0, tc0);
    end
    checks++;
    if (q3 !== 4'd0 || tc3 !== 1'b0 || q4 !== 4'd0) begin
      failures++;
      $display("FAIL reset_u3_u4 q3=%0d tc3=%0b q4=%0d expected 0 0 0", q3, tc3, q4);
    end
  endtask

  task automatic test_count_up_wrap();
    logic [3:0] exp_q;
    logic       exp_tc;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      tick();
      exp_q  = 4'(i % 16);
      exp_tc = (i == 16);
      checks++;
      if (q0 !== exp_q || tc0 !== exp_tc) begin
        failures++;
        $display("FAIL up_wrap step%0d q=%0d tc=%0b expected q=%0d tc=%0b", i, q0, tc0, exp_q, exp_tc);
      end
    end
  endtask

  task automatic test_count_down_mod10();
    logic [3:0] exp_q [4];
    logic       exp_tc[4];
    exp_q  = '{4'd1, 4'd0, 4'd9, 4'd8};
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    checks++;
    if (q1 !== 4'd2 || tc1 !== 1'b0) begin
      failures++;
      $display("FAIL down_load q=%0d tc=%0b expected q=2 tc=0", q1, tc1);
    end
    up = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q1 !== exp_q[i] || tc1 !== exp_tc[i]) begin
        failures++;
        $display("FAIL down_mod10 step%0d q=%0d tc=%0b expected q=%0d tc=%0b", i, q1, tc1, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_q [5];
    logic       exp_tc[5];
    exp_q  = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q2 !== exp_q[i] || tc2 !== exp_tc[i]) begin
        failures++;
        $display("FAIL sat_up step%0d q=%0d tc=%0b expected q=%0d tc=%0b", i, q2, tc2, exp_q[i], exp_tc[i]);
      end
    end
    en = 1'b0;
    do_reset();
    up = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (q2 !== 4'd0 || tc2 !== 1'b1) begin
      failures++;
      $display("FAIL sat_down_zero q=%0d tc=%0b expected q=0 tc=1", q2, tc2);
    end
  endtask

  task automatic test_prescale();
    logic [3:0] exp_q;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_q = 4'(i / 3);
      checks++;
      if (q3 !== exp_q) begin
        failures++;
        $display("FAIL prescale step%0d q=%0d expected %0d", i, q3, exp_q);
      end
    end
    // phase is now 1; gap of 2 disabled cycles pushes the next step out by 2
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q3 !== 4'd2) begin
        failures++;
        $display("FAIL prescale_gap cyc%0d q=%0d expected 2", i, q3);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (q3 !== 4'd2) begin
      failures++;
      $display("FAIL prescale_resume_early q=%0d expected 2", q3);
    end
    tick();
    checks++;
    if (q3 !== 4'd3) begin
      failures++;
      $display("FAIL prescale_resume_step q=%0d expected 3", q3);
    end
    // load freezes the phase: after 2 enabled cycles, load, then one more cycle steps
    do_reset();
    en = 1'b1;
    tick();
    tick();
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0;
    checks++;
    if (q3 !== 4'd9) begin
      failures++;
      $display("FAIL prescale_load q=%0d expected 9", q3);
    end
    tick();
    checks++;
    if (q3 !== 4'd10) begin
      failures++;
      $display("FAIL prescale_hold_phase q=%0d expected 10", q3);
    end
  endtask

  task automatic test_load_clear_reset();
    do_reset();
    load = 1'b1; load_val = 4'd15;
    tick();
    checks++;
    if (q4 !== 4'd11 || q0 !== 4'd15) begin
      failures++;
      $display("FAIL load_clamp q4=%0d q0=%0d expected q4=11 q0=15", q4, q0);
    end
    clear = 1'b1; load_val = 4'd7;
    tick();
    clear = 1'b0;
    checks++;
    if (q4 !== 4'd0 || tc4 !== 1'b0) begin
      failures++;
      $display("FAIL clear_over_load q=%0d tc=%0b expected q=0 tc=0", q4, tc4);
    end
    // load beats a coincident step
    en = 1'b1; up = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    checks++;
    if (q0 !== 4'd5 || q4 !== 4'd5) begin
      failures++;
      $display("FAIL load_over_step q0=%0d q4=%0d expected 5 5", q0, q4);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (q4 !== 4'd0 || tc4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_count q=%0d tc=%0b expected q=0 tc=0", q4, tc4);
    end
    en = 1'b0; load = 1'b1; load_val = 4'd11;
    tick();
    load = 1'b0; en = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (q4 !== 4'd0 || tc4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending_tc q=%0d tc=%0b expected q=0 tc=0", q4, tc4);
    end
    en = 1'b0; load = 1'b1; load_val = 4'd11;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (q4 !== 4'd0 || tc4 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_mod12 q=%0d tc=%0b expected q=0 tc=1", q4, tc4);
    end
    en = 1'b0; load = 1'b1; load_val = 4'd11;
    tick();
    load = 1'b0; en = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (q4 !== 4'd0 || tc4 !== 1'b0) begin
      failures++;
      $display("FAIL clear_pending_tc q=%0d tc=%0b expected q=0 tc=0", q4, tc4);
    end
  endtask

  task automatic test_match_and_direction();
    logic exp_m;
    do_reset();
    cmp_val = 4'd6;
    #1;
    checks++;
    if (m0 !== 1'b0) begin
      failures++;
      $display("FAIL match_idle m=%0b expected 0", m0);
    end
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_m = (i == 6);
      checks++;
      if (q0 !== 4'(i) || m0 !== exp_m) begin
        failures++;
        $display("FAIL match_up step%0d q=%0d m=%0b expected q=%0d m=%0b", i, q0, m0, i, exp_m);
      end
    end
    up = 1'b0;
    tick();
    checks++;
    if (q0 !== 4'd5 || m0 !== 1'b0) begin
      failures++;
      $display("FAIL dir_toggle q=%0d m=%0b expected q=5 m=0", q0, m0);
    end
    en = 1'b0;
    cmp_val = 4'd5;
    #1;
    checks++;
    if (m0 !== 1'b1) begin
      failures++;
      $display("FAIL match_comb m=%0b expected 1", m0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    en       = 1'b0;
    up       = 1'b1;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    cmp_val  = 4'd0;
    test_reset();
    test_count_up_wrap();
    test_count_down_mod10();
    test_saturate();
    test_prescale();
    test_load_clear_reset();
    test_match_and_direction();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
